// File: rtl/gru_gate_mac_element_if.sv
// Gate handshake bundle between the GRU cell controller (master) and one
// gate MAC element (slave).
interface gru_gate_mac_element_if #(
  parameter int D          = 128,
  parameter int H          = 256,
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic [D-1:0][DATA_WIDTH-1:0] x_t;
  logic [D-1:0][DATA_WIDTH-1:0] W_x_row;
  logic [H-1:0][DATA_WIDTH-1:0] h_t_prev;
  logic [H-1:0][DATA_WIDTH-1:0] W_h_row;
  logic [DATA_WIDTH-1:0]        b_x;
  logic [DATA_WIDTH-1:0]        b_h;
  logic [DATA_WIDTH-1:0]        r_t_n;
  logic [DATA_WIDTH-1:0]        y_n;
  logic                         valid_out;

  modport master (
    output valid_in, x_t, W_x_row, h_t_prev, W_h_row, b_x, b_h, r_t_n,
    input  y_n, valid_out
  );

  modport slave (
    input  valid_in, x_t, W_x_row, h_t_prev, W_h_row, b_x, b_h, r_t_n,
    output y_n, valid_out
  );
endinterface

// File: rtl/gru_gate_mac_element.sv
// One GRU gate output: lane-parallel dot products, bias add, PWL sigmoid/tanh.
// Optional GRU_GATE_OVF_FLAG_EN adds the ovf port flagging pre-activation saturation.
module gru_gate_mac_element #(
  parameter int D          = 128,
  parameter int H          = 256,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 4,
  parameter int GATE_KIND  = 0
) (
  input  logic clk,
  input  logic rst,
`ifdef GRU_GATE_OVF_FLAG_EN
  gru_gate_mac_element_if.slave bus,
  output logic ovf
`else
  gru_gate_mac_element_if.slave bus
`endif
);
  localparam int MAXDH = (D > H) ? D : H;
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(MAXDH) + 2;
  localparam int PW    = 2*DATA_WIDTH;
  localparam int KW    = $clog2(MAXDH + LANES) + 1;
  localparam int XIW   = (D > 1) ? $clog2(D) : 1;
  localparam int HIW   = (H > 1) ? $clog2(H) : 1;
  localparam int MW    = ACC_W + DATA_WIDTH + 1;
  localparam int AW    = DATA_WIDTH + 2;

  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {{(MW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0] ONE     = AW'(1 << FRAC_BITS);
  localparam logic signed [AW-1:0] HALF    = AW'(1 << (FRAC_BITS-1));
  localparam logic signed [AW-1:0] NEG_ONE = -ONE;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC_X, S_MAC_H, S_COMBINE, S_ACTIVATE, S_DONE
  } state_t;

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic signed [ACC_W-1:0] r_acc_x, r_acc_h;
  logic signed [DATA_WIDTH-1:0] r_pre, r_y;
  logic                    r_valid;
  logic signed [ACC_W-1:0] w_lane_sum;
  logic signed [DATA_WIDTH-1:0] w_pre_sat, w_act;
  logic                    w_pre_ovf;
  logic                    w_last_x, w_last_h;
`ifdef GRU_GATE_OVF_FLAG_EN
  logic r_pre_ovf, r_ovf;
  assign ovf = r_ovf;
`endif

  assign bus.y_n       = r_y;
  assign bus.valid_out = r_valid;
  assign w_last_x      = (r_k + KW'(LANES)) >= KW'(D);
  assign w_last_h      = (r_k + KW'(LANES)) >= KW'(H);

  // Lanes past the end of the vector contribute zero.
  always_comb begin
    logic [KW-1:0]          idx;
    logic signed [PW-1:0]   prod;
    idx        = '0;
    prod       = '0;
    w_lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx  = r_k + KW'(l);
      prod = '0;
      if (r_state == S_MAC_X && idx < KW'(D))
        prod = PW'($signed(bus.W_x_row[idx[XIW-1:0]])) * PW'($signed(bus.x_t[idx[XIW-1:0]]));
      else if (r_state == S_MAC_H && idx < KW'(H))
        prod = PW'($signed(bus.W_h_row[idx[HIW-1:0]])) * PW'($signed(bus.h_t_prev[idx[HIW-1:0]]));
      w_lane_sum = w_lane_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] sx, sh;
    logic signed [MW-1:0]    full;
    sx = (r_acc_x >>> FRAC_BITS) + ACC_W'($signed(bus.b_x));
    sh = (r_acc_h >>> FRAC_BITS) + ACC_W'($signed(bus.b_h));
    if (GATE_KIND == 0)
      full = MW'(sx) + MW'(sh);
    else
      full = MW'(sx) + ((MW'($signed(bus.r_t_n)) * MW'(sh)) >>> FRAC_BITS);
    w_pre_ovf = 1'b0;
    if (full > SAT_MAX) begin
      w_pre_sat = SAT_MAX[DATA_WIDTH-1:0];
      w_pre_ovf = 1'b1;
    end else if (full < SAT_MIN) begin
      w_pre_sat = SAT_MIN[DATA_WIDTH-1:0];
      w_pre_ovf = 1'b1;
    end else begin
      w_pre_sat = full[DATA_WIDTH-1:0];
    end
  end

  // Sigmoid: pre/4 + 0.5 clamped to [0,1]; tanh: pre clamped to [-1,1].
  always_comb begin
    logic signed [AW-1:0] a;
    if (GATE_KIND == 0) begin
      a = AW'(r_pre >>> 2) + HALF;
      if (a < 0)        a = '0;
      else if (a > ONE) a = ONE;
    end else begin
      a = AW'(r_pre);
      if (a < NEG_ONE)  a = NEG_ONE;
      else if (a > ONE) a = ONE;
    end
    w_act = a[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_acc_x <= '0;
      r_acc_h <= '0;
      r_pre   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
`ifdef GRU_GATE_OVF_FLAG_EN
      r_pre_ovf <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (bus.valid_in) begin
            r_acc_x <= '0;
            r_acc_h <= '0;
            r_k     <= '0;
            r_state <= S_MAC_X;
          end
        end
        S_MAC_X: begin
          if (!bus.valid_in) r_state <= S_IDLE;
          else begin
            r_acc_x <= r_acc_x + w_lane_sum;
            if (w_last_x) begin
              r_k     <= '0;
              r_state <= S_MAC_H;
            end else r_k <= r_k + KW'(LANES);
          end
        end
        S_MAC_H: begin
          if (!bus.valid_in) r_state <= S_IDLE;
          else begin
            r_acc_h <= r_acc_h + w_lane_sum;
            if (w_last_h) begin
              r_k     <= '0;
              r_state <= S_COMBINE;
            end else r_k <= r_k + KW'(LANES);
          end
        end
        S_COMBINE: begin
          if (!bus.valid_in) r_state <= S_IDLE;
          else begin
            r_pre   <= w_pre_sat;
`ifdef GRU_GATE_OVF_FLAG_EN
            r_pre_ovf <= w_pre_ovf;
`endif
            r_state <= S_ACTIVATE;
          end
        end
        S_ACTIVATE: begin
          if (!bus.valid_in) r_state <= S_IDLE;
          else begin
            r_y     <= w_act;
            r_valid <= 1'b1;
`ifdef GRU_GATE_OVF_FLAG_EN
            r_ovf   <= r_pre_ovf;
`endif
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.valid_in) begin
            r_valid <= 1'b0;
`ifdef GRU_GATE_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gru_gate_mac_element.sv
// Directed bench: one sigmoid-gate and one tanh-gate instance share stimulus,
// D=4, H=4, LANES=2, Q8 values; expected outputs are hand-computed.
module tb_gru_gate_mac_element;
  localparam int D  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic                 vin;
  logic [D-1:0][DW-1:0] x, wx;
  logic [H-1:0][DW-1:0] h, wh;
  logic [DW-1:0]        bx, bh, rt;

  gru_gate_mac_element_if #(.D(D), .H(H), .DATA_WIDTH(DW)) if0 ();
  gru_gate_mac_element_if #(.D(D), .H(H), .DATA_WIDTH(DW)) if1 ();

  assign if0.valid_in = vin;  assign if1.valid_in = vin;
  assign if0.x_t      = x;    assign if1.x_t      = x;
  assign if0.W_x_row  = wx;   assign if1.W_x_row  = wx;
  assign if0.h_t_prev = h;    assign if1.h_t_prev = h;
  assign if0.W_h_row  = wh;   assign if1.W_h_row  = wh;
  assign if0.b_x      = bx;   assign if1.b_x      = bx;
  assign if0.b_h      = bh;   assign if1.b_h      = bh;
  assign if0.r_t_n    = rt;   assign if1.r_t_n    = rt;

`ifdef GRU_GATE_OVF_FLAG_EN
  logic ovf0, ovf1;
`endif

  gru_gate_mac_element #(.D(D), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(2), .GATE_KIND(0)) u_g0 (
    .clk(clk), .rst(rst), .bus(if0)
`ifdef GRU_GATE_OVF_FLAG_EN
    , .ovf(ovf0)
`endif
  );

  gru_gate_mac_element #(.D(D), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(2), .GATE_KIND(1)) u_g1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef GRU_GATE_OVF_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    x = '0; wx = '0; h = '0; wh = '0; bx = '0; bh = '0; rt = '0;
  endtask

  // Raise the request and count edges until valid_out; latency excludes the sampling edge.
  task automatic request(input string tag, input int exp_y0, input int exp_y1, input int exp_ovf);
    int n;
    n   = 0;
    vin = 1'b1;
    while (!if0.valid_out && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n - 1, 6);
    check_val({tag, "_v1"}, longint'(if1.valid_out), 1);
    check_val({tag, "_y0"}, longint'($signed(if0.y_n)), exp_y0);
    check_val({tag, "_y1"}, longint'($signed(if1.y_n)), exp_y1);
`ifdef GRU_GATE_OVF_FLAG_EN
    check_val({tag, "_ovf0"}, longint'(ovf0), exp_ovf);
    check_val({tag, "_ovf1"}, longint'(ovf1), exp_ovf);
`else
    if (exp_ovf > 1) $display("note: %s unexpected ovf expectation", tag);
`endif
  endtask

  task automatic release_req(input string tag);
    vin = 1'b0;
    tick();
    check_val({tag, "_rel_v0"}, longint'(if0.valid_out), 0);
    check_val({tag, "_rel_v1"}, longint'(if1.valid_out), 0);
`ifdef GRU_GATE_OVF_FLAG_EN
    check_val({tag, "_rel_ovf0"}, longint'(ovf0), 0);
`endif
  endtask

  initial begin
    int seen;
    vin = 1'b0;
    clear_ops();
    rst = 1'b1;
    repeat (3) tick();
    check_val("rst_v0", longint'(if0.valid_out), 0);
    check_val("rst_y0", longint'($signed(if0.y_n)), 0);
    check_val("rst_y1", longint'($signed(if1.y_n)), 0);
    rst = 1'b0;
    tick();

    // zero operands: sigmoid midpoint, tanh zero
    request("t1", 128, 0, 0);
    release_req("t1");

    clear_ops();
    wx[0] = 16'd256; x[0] = 16'd64;
    request("t2a", 144, 64, 0);
    release_req("t2a");
    bh = 16'(-1024);
    request("t2b", 0, 64, 0);
    release_req("t2b");

    clear_ops();
    wh[0] = 16'd256; h[0] = 16'd512; rt = 16'd128;
    request("t3a", 256, 256, 0);
    release_req("t3a");
    rt = 16'd64;
    request("t3b", 256, 128, 0);
    release_req("t3b");
    bx = 16'(-512);
    request("t3c", 128, -256, 0);
    release_req("t3c");

    // hold in DONE with changed operands: result must not be recomputed
    clear_ops();
    wx[0] = 16'd256; x[0] = 16'd64;
    request("t4", 144, 64, 0);
    x[0] = 16'd128;
    repeat (5) tick();
    check_val("t4_hold_v0", longint'(if0.valid_out), 1);
    check_val("t4_hold_y0", longint'($signed(if0.y_n)), 144);
    check_val("t4_hold_y1", longint'($signed(if1.y_n)), 64);
    release_req("t4");
    request("t4_re", 160, 128, 0);
    release_req("t4_re");

    // abort during MAC_H: operands that would give y0=0 must not reach y_n
    clear_ops();
    wx[0] = 16'd256; x[0] = 16'd64; bh = 16'(-1024);
    vin = 1'b1;
    repeat (3) tick();
    vin = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (if0.valid_out) seen++;
    end
    check_val("t5_abort_v", seen, 0);
    check_val("t5_abort_y0", longint'($signed(if0.y_n)), 160);

    // reset during MAC_X
    vin = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_val("t5_rst_y0", longint'($signed(if0.y_n)), 0);
    check_val("t5_rst_v0", longint'(if0.valid_out), 0);
    check_val("t5_rst_y1", longint'($signed(if1.y_n)), 0);
    rst = 1'b0;
    request("t5_after", 0, 64, 0);
    release_req("t5_after");

    // saturation
    clear_ops();
    for (int i = 0; i < 4; i++) begin
      wx[i] = 16'h7FFF; x[i] = 16'h7FFF; wh[i] = 16'h7FFF; h[i] = 16'h7FFF;
    end
    request("t6", 256, 256, 1);
    release_req("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
